// File: rtl/qm_defs_pkg.sv
// Shared definitions for the qm front end: fetch FSM encodings, the default
// boot address and a word-alignment helper used by the fetch stage and the
// instruction cache.
package qm_defs_pkg;

  // Fetch FSM encodings (2 bits, shared with qm_icache and later stages)
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    MISS  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  // Boot address: MIPS-style kseg1 boot ROM
  localparam logic [31:0] QM_RESET_VECTOR = 32'hBFC00000;

  // Force an address onto a 32-bit instruction boundary
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/qm_fetch.sv
// Instruction fetch stage. Presents the PC to qm_icache, registers the
// returned word toward decode with a valid/ready handshake, parks on cache
// misses and decode back-pressure, and applies branch redirects. A redirect
// that arrives while a line fill is in flight is parked in a pending register
// so the fill address stays put until the cache answers.
module qm_fetch
  import qm_defs_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = QM_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] icache_address,
  input  logic        icache_hit,
  input  logic        icache_stall,
  input  logic [31:0] icache_data,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic        decode_ready,
  output logic        decode_valid,
  output logic [31:0] decode_instr,
  output logic [31:0] decode_pc,
  output logic [15:0] miss_cycles
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic         pending_valid_reg, pending_valid_next;
  logic [31:0]  pending_target_reg, pending_target_next;
  logic         decode_valid_next;
  logic [31:0]  decode_instr_next, decode_pc_next;
  logic [15:0]  miss_cycles_next;

  logic redirect;
  logic issue;
  logic take_branch;

  assign icache_address = pc_reg;

  // Next-state logic for the FSM, PC, pending redirect and decode register
  always_comb begin
    state_next          = state_reg;
    pc_next             = pc_reg;
    pending_valid_next  = pending_valid_reg;
    pending_target_next = pending_target_reg;
    decode_valid_next   = decode_valid;
    decode_instr_next   = decode_instr;
    decode_pc_next      = decode_pc;
    miss_cycles_next    = miss_cycles;

    redirect    = branch_valid || pending_valid_reg;
    issue       = icache_hit && (!decode_valid || decode_ready) && !redirect;
    // Outside MISS a redirect is applied at once; inside MISS it is deferred
    take_branch = branch_valid && (state_reg != MISS);

    // Program counter and pending redirect; the newest branch always wins
    if (take_branch) begin
      pc_next            = word_align(branch_target);
      pending_valid_next = 1'b0;
    end else if (branch_valid) begin
      pending_valid_next  = 1'b1;
      pending_target_next = word_align(branch_target);
    end else if (pending_valid_reg && icache_hit) begin
      // The hit belongs to the abandoned path: drop it and jump
      pc_next            = pending_target_reg;
      pending_valid_next = 1'b0;
    end else if (issue) begin
      pc_next = pc_reg + 32'd4;
    end

    // Decode output register: flush beats load, load beats drain
    if (take_branch) begin
      decode_valid_next = 1'b0;
    end else if (issue) begin
      decode_valid_next = 1'b1;
      decode_instr_next = icache_data;
      decode_pc_next    = pc_reg;
    end else if (decode_valid && decode_ready) begin
      decode_valid_next = 1'b0;
    end

    // Fetch FSM
    case (state_reg)
      FETCH: begin
        if (take_branch)
          state_next = FETCH;
        else if (icache_stall)
          state_next = MISS;
        else if (icache_hit && decode_valid && !decode_ready)
          state_next = HOLD;
      end
      MISS: begin
        if (icache_hit)
          state_next = FETCH;
      end
      HOLD: begin
        if (take_branch || decode_ready)
          state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase

    // Saturating count of cycles spent waiting on a line fill
    if ((state_reg == MISS) && (miss_cycles != 16'hFFFF))
      miss_cycles_next = miss_cycles + 16'd1;
  end

  // State, PC, pending redirect and decode output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg          <= FETCH;
      pc_reg             <= word_align(RESET_VECTOR);
      pending_valid_reg  <= 1'b0;
      pending_target_reg <= 32'd0;
      decode_valid       <= 1'b0;
      decode_instr       <= 32'd0;
      decode_pc          <= 32'd0;
      miss_cycles        <= 16'd0;
    end else begin
      state_reg          <= state_next;
      pc_reg             <= pc_next;
      pending_valid_reg  <= pending_valid_next;
      pending_target_reg <= pending_target_next;
      decode_valid       <= decode_valid_next;
      decode_instr       <= decode_instr_next;
      decode_pc          <= decode_pc_next;
      miss_cycles        <= miss_cycles_next;
    end
  end

endmodule
